// File: rtl/line_refill_adapter_pkg.sv
// Shared types and geometry for the line refill adapter.
// Bus/line widths are fixed here so the interface and the adapter agree.
package line_refill_adapter_pkg;

  localparam int unsigned ADDR_WIDTH       = 32;
  localparam int unsigned WORD_WIDTH       = 32;
  localparam int unsigned LINE_WORDS       = 4;
  localparam int unsigned ID_WIDTH         = 4;

  localparam int unsigned WORD_BYTES       = WORD_WIDTH / 8;
  localparam int unsigned LINE_BYTES       = LINE_WORDS * WORD_BYTES;
  localparam int unsigned LINE_OFFSET_BITS = $clog2(LINE_BYTES);
  localparam int unsigned WORD_OFFSET_BITS = $clog2(WORD_BYTES);
  localparam int unsigned WORD_IDX_BITS    = $clog2(LINE_WORDS);
  localparam int unsigned LINE_WIDTH       = LINE_WORDS * WORD_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } refill_state_e;

  // Byte address of word idx within a line-aligned base.
  function automatic logic [ADDR_WIDTH-1:0] word_addr(input logic [ADDR_WIDTH-1:0]    base,
                                                     input logic [WORD_IDX_BITS-1:0] idx);
    return base + (ADDR_WIDTH'(idx) << WORD_OFFSET_BITS);
  endfunction

endpackage

// File: rtl/line_refill_adapter_if.sv
// Refill request/response and memory bus signals of the line refill adapter.
// slave = adapter view, master = cache/memory environment view.
interface line_refill_adapter_if;
  import line_refill_adapter_pkg::*;

  logic                  req_valid_i;
  logic                  req_ready_o;
  logic [ADDR_WIDTH-1:0] req_addr_i;
  logic [ID_WIDTH-1:0]   req_id_i;

  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic [LINE_WIDTH-1:0] rsp_data_o;
  logic [ID_WIDTH-1:0]   rsp_id_o;
  logic                  rsp_error_o;

  logic                  mem_valid_o;
  logic                  mem_ready_i;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic                  mem_rvalid_i;
  logic [WORD_WIDTH-1:0] mem_rdata_i;
  logic                  mem_err_i;

  modport slave (
    input  req_valid_i, req_addr_i, req_id_i, rsp_ready_i,
           mem_ready_i, mem_rvalid_i, mem_rdata_i, mem_err_i,
    output req_ready_o, rsp_valid_o, rsp_data_o, rsp_id_o, rsp_error_o,
           mem_valid_o, mem_addr_o
  );

  modport master (
    output req_valid_i, req_addr_i, req_id_i, rsp_ready_i,
           mem_ready_i, mem_rvalid_i, mem_rdata_i, mem_err_i,
    input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_id_o, rsp_error_o,
           mem_valid_o, mem_addr_o
  );

endinterface

// File: rtl/line_refill_adapter.sv
// Turns one cache-line refill into single-word bus reads and returns the assembled line.
// Build option: REFILL_CRITICAL_WORD_FIRST_EN starts the fetch at the missed word and wraps.
module line_refill_adapter
  import line_refill_adapter_pkg::*;
(
  input logic                  clk_i,
  input logic                  rst_i,
  line_refill_adapter_if.slave bus
);

  refill_state_e              state_q, state_d;
  logic [ADDR_WIDTH-1:0]      base_q, base_d;
  logic [ADDR_WIDTH-1:0]      addr_q, addr_d;
  logic [WORD_IDX_BITS-1:0]   idx_q, idx_d;
  logic [WORD_IDX_BITS-1:0]   beat_q, beat_d;
  logic [LINE_WIDTH-1:0]      data_q, data_d;
  logic [ID_WIDTH-1:0]        id_q, id_d;
  logic                       err_q, err_d;
  logic [WORD_IDX_BITS-1:0]   start_idx;
  logic                       unused_addr_bits;

`ifdef REFILL_CRITICAL_WORD_FIRST_EN
  assign start_idx = bus.req_addr_i[LINE_OFFSET_BITS-1:WORD_OFFSET_BITS];
`else
  assign start_idx = '0;
`endif

  // Offset bits only matter for the start index; the line base drops them.
  assign unused_addr_bits = ^bus.req_addr_i[LINE_OFFSET_BITS-1:0];

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    addr_d  = addr_q;
    idx_d   = idx_q;
    beat_d  = beat_q;
    data_d  = data_q;
    id_d    = id_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (bus.req_valid_i) begin
          base_d  = bus.req_addr_i & ~ADDR_WIDTH'(LINE_BYTES - 1);
          addr_d  = word_addr(base_d, start_idx);
          idx_d   = start_idx;
          beat_d  = '0;
          data_d  = '0;
          id_d    = bus.req_id_i;
          err_d   = 1'b0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.mem_ready_i) state_d = WAIT;
      end
      WAIT: begin
        if (bus.mem_rvalid_i) begin
          if (bus.mem_err_i) begin
            // Abandon the line: remaining slots stay zero.
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            for (int unsigned k = 0; k < LINE_WORDS; k++) begin
              if (idx_q == WORD_IDX_BITS'(k)) data_d[k*WORD_WIDTH +: WORD_WIDTH] = bus.mem_rdata_i;
            end
            idx_d  = idx_q + WORD_IDX_BITS'(1);
            beat_d = beat_q + WORD_IDX_BITS'(1);
            if (beat_q == WORD_IDX_BITS'(LINE_WORDS - 1)) begin
              state_d = RESP;
            end else begin
              addr_d  = word_addr(base_q, idx_d);
              state_d = ISSUE;
            end
          end
        end
      end
      RESP: begin
        if (bus.rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      base_q  <= '0;
      addr_q  <= '0;
      idx_q   <= '0;
      beat_q  <= '0;
      data_q  <= '0;
      id_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      beat_q  <= beat_d;
      data_q  <= data_d;
      id_q    <= id_d;
      err_q   <= err_d;
    end
  end

  assign bus.req_ready_o = (state_q == IDLE);
  assign bus.mem_valid_o = (state_q == ISSUE);
  assign bus.rsp_valid_o = (state_q == RESP);
  assign bus.mem_addr_o  = addr_q;
  assign bus.rsp_data_o  = data_q;
  assign bus.rsp_id_o    = id_q;
  assign bus.rsp_error_o = err_q;

endmodule

// File: tb/tb_line_refill_adapter.sv
// Directed bench for line_refill_adapter: refill vectors from a table plus a reset-abort sequence.
`timescale 1ns/1ps
module tb_line_refill_adapter;

  localparam logic [31:0] NONE = 32'd99;

  typedef struct packed {
    logic [31:0]       addr;
    logic [3:0]        id;
    logic [31:0]       seed;
    logic [31:0]       stall_beat;
    logic [31:0]       stall_cyc;
    logic [31:0]       rsp_stall;
    logic [31:0]       err_beat;
    logic [31:0]       n_issue;
    logic [3:0][31:0]  exp_addr;
    logic [127:0]      exp_data;
    logic              exp_err;
    logic [31:0]       exp_lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  line_refill_adapter_if bus ();

  line_refill_adapter dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  vec_t        vecs [6];
  vec_t        cur;
  logic        pend;
  logic [31:0] pend_addr;
  int unsigned pend_beat;
  int unsigned hs_n;
  int unsigned stall_left;
  logic        prev_stall;
  logic [31:0] prev_addr;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] addr, input logic [3:0] id, input logic [31:0] seed,
                              input logic [31:0] stall_beat, input logic [31:0] stall_cyc,
                              input logic [31:0] rsp_stall, input logic [31:0] err_beat,
                              input logic [31:0] n_issue,
                              input logic [31:0] a0, input logic [31:0] a1,
                              input logic [31:0] a2, input logic [31:0] a3,
                              input logic [127:0] data, input logic err, input logic [31:0] lat);
    vec_t v;
    v.addr = addr; v.id = id; v.seed = seed;
    v.stall_beat = stall_beat; v.stall_cyc = stall_cyc; v.rsp_stall = rsp_stall;
    v.err_beat = err_beat; v.n_issue = n_issue;
    v.exp_addr[0] = a0; v.exp_addr[1] = a1; v.exp_addr[2] = a2; v.exp_addr[3] = a3;
    v.exp_data = data; v.exp_err = err; v.exp_lat = lat;
    return v;
  endfunction

  // One cycle of the memory model, advanced on the falling edge.
  task automatic tick();
    @(negedge clk);
    bus.mem_rvalid_i = pend;
    bus.mem_err_i    = 1'b0;
    bus.mem_rdata_i  = 32'h0;
    if (pend) begin
      if (32'(pend_beat) == cur.err_beat) begin
        bus.mem_err_i   = 1'b1;
        bus.mem_rdata_i = 32'hDEAD_BEEF;
      end else begin
        bus.mem_rdata_i = cur.seed + 32'(pend_addr[3:2]);
      end
    end
    if (prev_stall) check("mem_hold", 160'({bus.mem_valid_o, bus.mem_addr_o}), 160'({1'b1, prev_addr}));
    if (bus.mem_valid_o && 32'(hs_n) == cur.stall_beat && stall_left > 0) begin
      bus.mem_ready_i = 1'b0;
      stall_left--;
      prev_stall = 1'b1;
      prev_addr  = bus.mem_addr_o;
    end else begin
      bus.mem_ready_i = 1'b1;
      prev_stall = 1'b0;
    end
    pend = bus.mem_valid_o && bus.mem_ready_i;
    if (pend) begin
      if (32'(hs_n) < cur.n_issue) check("mem_addr", 160'(bus.mem_addr_o), 160'(cur.exp_addr[hs_n]));
      pend_addr = bus.mem_addr_o;
      pend_beat = hs_n;
      hs_n++;
    end
  endtask

  task automatic start_req(input vec_t v);
    cur = v; hs_n = 0; stall_left = v.stall_cyc; prev_stall = 1'b0; pend = 1'b0;
    bus.req_valid_i = 1'b1;
    bus.req_addr_i  = v.addr;
    bus.req_id_i    = v.id;
    bus.rsp_ready_i = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int unsigned cyc;
    int unsigned lat;
    logic        ready_bad;
    logic [134:0] snap;
    check("req_ready_idle", 160'(bus.req_ready_o), 160'(1'b1));
    start_req(v);
    cyc = 0; lat = 0; ready_bad = 1'b0;
    while (lat == 0 && cyc < 100) begin
      tick();
      cyc++;
      if (cyc == 1) begin
        bus.req_valid_i = 1'b0;
        check("mem_valid_first", 160'(bus.mem_valid_o), 160'(1'b1));
      end
      if (bus.rsp_valid_o) lat = cyc;
      else if (bus.req_ready_o) ready_bad = 1'b1;
    end
    check("rsp_latency", 160'(lat), 160'(v.exp_lat));
    check("req_ready_busy", 160'(ready_bad), 160'(1'b0));
    check("rsp_data", 160'(bus.rsp_data_o), 160'(v.exp_data));
    check("rsp_id", 160'(bus.rsp_id_o), 160'(v.id));
    check("rsp_error", 160'(bus.rsp_error_o), 160'(v.exp_err));
    check("issue_count", 160'(hs_n), 160'(v.n_issue));
    snap = {bus.rsp_valid_o, bus.req_ready_o, bus.rsp_error_o, bus.rsp_id_o, bus.rsp_data_o};
    for (int unsigned i = 0; i < v.rsp_stall; i++) begin
      tick();
      check("rsp_hold", 160'({bus.rsp_valid_o, bus.req_ready_o, bus.rsp_error_o, bus.rsp_id_o,
                               bus.rsp_data_o}), 160'(snap));
    end
    bus.rsp_ready_i = 1'b1;
    tick();
    bus.rsp_ready_i = 1'b0;
    check("idle_after_rsp", 160'({bus.req_ready_o, bus.rsp_valid_o}), 160'(2'b10));
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_req_ready"}, 160'(bus.req_ready_o), 160'(1'b1));
    check({name, "_mem_valid"}, 160'(bus.mem_valid_o), 160'(1'b0));
    check({name, "_mem_addr"},  160'(bus.mem_addr_o),  160'(32'h0));
    check({name, "_rsp_valid"}, 160'(bus.rsp_valid_o), 160'(1'b0));
    check({name, "_rsp_data"},  160'(bus.rsp_data_o),  160'(128'h0));
    check({name, "_rsp_id"},    160'(bus.rsp_id_o),    160'(4'h0));
    check({name, "_rsp_error"}, 160'(bus.rsp_error_o), 160'(1'b0));
  endtask

  initial begin
    bus.req_valid_i = 1'b0; bus.req_addr_i = '0; bus.req_id_i = '0; bus.rsp_ready_i = 1'b0;
    bus.mem_ready_i = 1'b0; bus.mem_rvalid_i = 1'b0; bus.mem_rdata_i = '0; bus.mem_err_i = 1'b0;
    pend = 1'b0; pend_addr = '0; pend_beat = 0; hs_n = 0; stall_left = 0;
    prev_stall = 1'b0; prev_addr = '0;

`ifdef REFILL_CRITICAL_WORD_FIRST_EN
    vecs[0] = mk(32'h1008, 4'h3, 32'hA0, NONE, 0, 0, NONE, 4,
                 32'h1008, 32'h100C, 32'h1000, 32'h1004,
                 128'h000000A3_000000A2_000000A1_000000A0, 1'b0, 9);
    vecs[1] = mk(32'h2344, 4'h5, 32'h1000_0000, 1, 3, 5, NONE, 4,
                 32'h2344, 32'h2348, 32'h234C, 32'h2340,
                 128'h10000003_10000002_10000001_10000000, 1'b0, 12);
    vecs[3] = mk(32'h400C, 4'hF, 32'h55, NONE, 0, 0, NONE, 4,
                 32'h400C, 32'h4000, 32'h4004, 32'h4008,
                 128'h00000058_00000057_00000056_00000055, 1'b0, 9);
    vecs[4] = mk(32'h5004, 4'h1, 32'h70, NONE, 0, 2, 0, 1,
                 32'h5004, 32'h0, 32'h0, 32'h0, 128'h0, 1'b1, 3);
`else
    vecs[0] = mk(32'h1008, 4'h3, 32'hA0, NONE, 0, 0, NONE, 4,
                 32'h1000, 32'h1004, 32'h1008, 32'h100C,
                 128'h000000A3_000000A2_000000A1_000000A0, 1'b0, 9);
    vecs[1] = mk(32'h2344, 4'h5, 32'h1000_0000, 1, 3, 5, NONE, 4,
                 32'h2340, 32'h2344, 32'h2348, 32'h234C,
                 128'h10000003_10000002_10000001_10000000, 1'b0, 12);
    vecs[3] = mk(32'h400C, 4'hF, 32'h55, NONE, 0, 0, NONE, 4,
                 32'h4000, 32'h4004, 32'h4008, 32'h400C,
                 128'h00000058_00000057_00000056_00000055, 1'b0, 9);
    vecs[4] = mk(32'h5004, 4'h1, 32'h70, NONE, 0, 2, 0, 1,
                 32'h5000, 32'h0, 32'h0, 32'h0, 128'h0, 1'b1, 3);
`endif
    vecs[2] = mk(32'h30F0, 4'hA, 32'hC0, NONE, 0, 0, 2, 3,
                 32'h30F0, 32'h30F4, 32'h30F8, 32'h0,
                 128'h00000000_00000000_000000C1_000000C0, 1'b1, 7);
    vecs[5] = mk(32'h6010, 4'h6, 32'h30, NONE, 0, 0, NONE, 4,
                 32'h6010, 32'h6014, 32'h6018, 32'h601C,
                 128'h00000033_00000032_00000031_00000030, 1'b0, 9);

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Abort a refill while its read is outstanding, then feed a stray read beat.
    start_req(mk(32'h7008, 4'h9, 32'hE0, NONE, 0, 0, NONE, 4,
                 32'h0, 32'h0, 32'h0, 32'h0, 128'h0, 1'b0, 9));
    cur.n_issue = 0;
    tick();
    bus.req_valid_i = 1'b0;
    tick();
    check("in_wait", 160'({bus.mem_valid_o, bus.req_ready_o, bus.rsp_valid_o, bus.mem_rvalid_i}),
          160'(4'b0001));
    rst = 1'b1;
    bus.mem_rvalid_i = 1'b0;
    pend = 1'b0;
    #1;
    check_reset_outputs("abort");
    @(negedge clk);
    rst = 1'b0;
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 32'hBAD0_BAD0;
    bus.mem_err_i    = 1'b0;
    @(negedge clk);
    bus.mem_rvalid_i = 1'b0;
    check("stray_ignored", 160'({bus.req_ready_o, bus.mem_valid_o, bus.rsp_valid_o, bus.rsp_data_o}),
          160'({1'b1, 1'b0, 1'b0, 128'h0}));
    run_vec(vecs[5]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
